tmds_encoder_8b10b: RTL

//  TMDS 8b/10b encoder for one HDMI/DVI channel. Sits directly upstream of the 10:1 OSERDESE3 serializer; its dout

---
 rtl/tmds_encoder_8b10b_if.sv | 29 ++
 rtl/tmds_encoder_8b10b.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder_8b10b_if.sv
// ---------------------------------------------------------------------------
// tmds_encoder_8b10b_if
// Symbol bus for one TMDS channel encoder. The video source drives the
// pixel/control/aux inputs, and the encoder returns the 10-bit symbol that
// feeds the serializer's txdata.
//
// Signals
//   de    video data enable
//   din   8-bit pixel component
//   ctrl  control bits {C1,C0}, used when de=0
//   ade   aux data enable (data-island period)
//   aux   TERC4 nibble
//   dout  encoded 10-bit symbol, dout[0] transmitted first
//
// Modports
//   master  source side: drives de/din/ctrl/ade/aux, receives dout
//   slave   encoder side: receives de/din/ctrl/ade/aux, drives dout
// ---------------------------------------------------------------------------
interface tmds_encoder_8b10b_if;
  logic       de;
  logic [7:0] din;
  logic [1:0] ctrl;
  logic       ade;
  logic [3:0] aux;
  logic [9:0] dout;

  modport master (output de, din, ctrl, ade, aux, input dout);
  modport slave  (input de, din, ctrl, ade, aux, output dout);
endinterface

// File: rtl/tmds_encoder_8b10b.sv
// ---------------------------------------------------------------------------
// tmds_encoder_8b10b
// TMDS 8b/10b encoder for one HDMI/DVI channel. Video pixels (de=1) are
// transition-minimised and then DC-balanced with a running disparity
// counter; blanking periods (de=0) send one of four control tokens. The
// output drives a 10:1 serializer directly, one symbol per pclk, with two
// register stages between the inputs and dout.
//
// Optional feature macro: TMDS_TERC4_EN
//   defined   -> de=0 & ade=1 sends the TERC4 code of aux (de has priority)
//   undefined -> ade/aux are ignored and de=0 always sends control tokens
//
// Parameters
//   CHANNEL  channel index 0..2, informational only
//
// Ports
//   pclk   pixel clock, single clock domain
//   txrst  synchronous active-high reset
//   bus    tmds_encoder_8b10b_if.slave symbol bus (de, din, ctrl, ade, aux, dout)
// ---------------------------------------------------------------------------
module tmds_encoder_8b10b #(
  parameter int CHANNEL = 0
) (
  input  logic                       pclk,
  input  logic                       txrst,
  tmds_encoder_8b10b_if.slave        bus
);

  localparam logic [9:0] TOKEN_00 = 10'b1101010100;

  function automatic logic [9:0] ctrl_token(input logic [1:0] c);
    logic [9:0] t;
    case (c)
      2'b00:   t = 10'b1101010100;
      2'b01:   t = 10'b0010101011;
      2'b10:   t = 10'b0101010100;
      default: t = 10'b1010101011;
    endcase
    return t;
  endfunction

`ifdef TMDS_TERC4_EN
  function automatic logic [9:0] terc4_code(input logic [3:0] a);
    logic [9:0] t;
    case (a)
      4'h0:    t = 10'b1010011100;
      4'h1:    t = 10'b1001100011;
      4'h2:    t = 10'b1011100100;
      4'h3:    t = 10'b1011100010;
      4'h4:    t = 10'b0101110001;
      4'h5:    t = 10'b0100011110;
      4'h6:    t = 10'b0110001110;
      4'h7:    t = 10'b0100111100;
      4'h8:    t = 10'b1011001100;
      4'h9:    t = 10'b0100111001;
      4'hA:    t = 10'b0110011100;
      4'hB:    t = 10'b1011000110;
      4'hC:    t = 10'b1010001110;
      4'hD:    t = 10'b1001110001;
      4'hE:    t = 10'b0101100011;
      default: t = 10'b1011000011;
    endcase
    return t;
  endfunction

  logic       ade_r;
  logic [3:0] aux_r;
  logic       unused_cfg;
  assign unused_cfg = (CHANNEL != 0);
`else
  // ade/aux have no function in this build; folding them here keeps them
  // visibly consumed without adding any real logic.
  logic unused_cfg;
  assign unused_cfg = ^{bus.ade, bus.aux} ^ (CHANNEL != 0);
`endif

  // Stage 1 combinational: choose XOR or XNOR chaining so the 8-bit word has
  // the fewest transitions. q_m[8] records which one was used (1 = XOR).
  logic [3:0] n1d;
  logic       use_xnor;
  logic [8:0] q_m;

  always_comb begin
    n1d = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1d = n1d + {3'd0, bus.din[i]};
    end
    use_xnor = (n1d > 4'd4) || ((n1d == 4'd4) && !bus.din[0]);
    q_m      = 9'd0;
    q_m[0]   = bus.din[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ bus.din[i]) : (q_m[i-1] ^ bus.din[i]);
    end
    q_m[8] = ~use_xnor;
  end

  logic [8:0] q_m_r;
  logic       de_r;
  logic [1:0] ctrl_r;

  // Stage 1 register: transition-minimised word plus the side-band fields
  // that select the symbol type in stage 2.
  always_ff @(posedge pclk) begin
    if (txrst) begin
      q_m_r  <= 9'd0;
      de_r   <= 1'b0;
      ctrl_r <= 2'b00;
`ifdef TMDS_TERC4_EN
      ade_r  <= 1'b0;
      aux_r  <= 4'h0;
`endif
    end else begin
      q_m_r  <= q_m;
      de_r   <= bus.de;
      ctrl_r <= bus.ctrl;
`ifdef TMDS_TERC4_EN
      ade_r  <= bus.ade;
      aux_r  <= bus.aux;
`endif
    end
  end

  // Stage 2 combinational: DC balancing. cnt holds the running ones-minus-
  // zeros of the symbols sent since the last non-video symbol; the word is
  // inverted whenever sending it as-is would push cnt further from zero.
  logic [3:0]        n1;
  logic signed [4:0] diff;
  logic signed [4:0] cnt;
  logic signed [4:0] cnt_next;
  logic [9:0]        dout_r;
  logic [9:0]        dout_next;

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + {3'd0, q_m_r[i]};
    end
    // n1 - n0 == 2*n1 - 8; modulo-32 wrap of {n1,0} still lands on the right value
    diff      = signed'({n1, 1'b0}) - 5'sd8;
    dout_next = TOKEN_00;
    cnt_next  = 5'sd0;
    if (de_r) begin
      if ((cnt == 5'sd0) || (n1 == 4'd4)) begin
        dout_next = {~q_m_r[8], q_m_r[8], q_m_r[8] ? q_m_r[7:0] : ~q_m_r[7:0]};
        cnt_next  = q_m_r[8] ? (cnt + diff) : (cnt - diff);
      end else if (((cnt > 5'sd0) && (n1 > 4'd4)) || ((cnt < 5'sd0) && (n1 < 4'd4))) begin
        dout_next = {1'b1, q_m_r[8], ~q_m_r[7:0]};
        cnt_next  = cnt + (q_m_r[8] ? 5'sd2 : 5'sd0) - diff;
      end else begin
        dout_next = {1'b0, q_m_r[8], q_m_r[7:0]};
        cnt_next  = cnt - (q_m_r[8] ? 5'sd0 : 5'sd2) + diff;
      end
    end else begin
`ifdef TMDS_TERC4_EN
      if (ade_r) begin
        dout_next = terc4_code(aux_r);
      end else begin
        dout_next = ctrl_token(ctrl_r);
      end
`else
      dout_next = ctrl_token(ctrl_r);
`endif
    end
  end

  // Stage 2 register: symbol to the serializer and the disparity counter.
  always_ff @(posedge pclk) begin
    if (txrst) begin
      dout_r <= TOKEN_00;
      cnt    <= 5'sd0;
    end else begin
      dout_r <= dout_next;
      cnt    <= cnt_next;
    end
  end

  assign bus.dout = dout_r;

endmodule
